// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: op encodings, size field values,
// FSM state enum and the op legality decode.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b11;

    // bit3 = store, bit2 = unsigned, bits[1:0] = size
    localparam logic [3:0] OP_LB  = 4'b0000;
    localparam logic [3:0] OP_LH  = 4'b0001;
    localparam logic [3:0] OP_LW  = 4'b0011;
    localparam logic [3:0] OP_LBU = 4'b0100;
    localparam logic [3:0] OP_LHU = 4'b0101;
    localparam logic [3:0] OP_SB  = 4'b1000;
    localparam logic [3:0] OP_SH  = 4'b1001;
    localparam logic [3:0] OP_SW  = 4'b1011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_CAP,
        ST_WR,
        ST_FIN
    } lsu_state_t;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Big-endian lane steering: extract/extend a load result and merge store data into a word.
// Latency: combinational. Backpressure: none (pure function of its inputs).
// Lane 0 is the most significant byte of the word.
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[31:24];
        case (i_lane)
            2'd0:    w_byte = i_word[31:24];
            2'd1:    w_byte = i_word[23:16];
            2'd2:    w_byte = i_word[15:8];
            default: w_byte = i_word[7:0];
        endcase
        w_half = i_lane[1] ? i_word[15:0] : i_word[31:16];
    end

    always_comb begin
        o_load = i_word;
        case (i_size)
            SZ_BYTE: o_load = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            SZ_HALF: o_load = {{16{~i_unsigned & w_half[15]}}, w_half};
            default: o_load = i_word;
        endcase
    end

    always_comb begin
        o_merged = i_word;
        case (i_size)
            SZ_BYTE: begin
                case (i_lane)
                    2'd0:    o_merged[31:24] = i_wdata[7:0];
                    2'd1:    o_merged[23:16] = i_wdata[7:0];
                    2'd2:    o_merged[15:8]  = i_wdata[7:0];
                    default: o_merged[7:0]   = i_wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                if (i_lane[1]) o_merged[15:0]  = i_wdata[15:0];
                else           o_merged[31:16] = i_wdata[15:0];
            end
            default: o_merged = i_wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// CPU-side initiator for a word-only data memory; sub-word stores done as read-modify-write.
// Latency: loads done at T+3, SW T+2, SB/SH T+4, fault/illegal T+1 (T = accept cycle).
// Backpressure: req_ready only in IDLE, one request in flight. Macro LSU_ALIGN_CHECK_EN adds alignment faults.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_DEPTH = 256
)
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        err,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    // The word index is never range-checked; a memory deeper than 2^30 words is simply unreachable.
    if (MEM_DEPTH > (1 << 30)) begin : g_depth_unreachable
    end

    lsu_state_t  r_state, w_next;
    logic [3:0]  r_op;
    logic [1:0]  r_lane;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic        r_err;

    logic        w_accept;
    logic        w_fault;
    logic [31:0] w_load;
    logic [31:0] w_merged;

    assign w_accept = (r_state == ST_IDLE) && req_valid;

    always_comb begin
        w_fault = ~op_legal(req_op);
`ifdef LSU_ALIGN_CHECK_EN
        if (req_op[1:0] == SZ_HALF && req_addr[0])          w_fault = 1'b1;
        if (req_op[1:0] == SZ_WORD && req_addr[1:0] != 2'b00) w_fault = 1'b1;
`endif
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (w_fault)             w_next = ST_FIN;
                    else if (req_op == OP_SW) w_next = ST_WR;
                    else                      w_next = ST_RD;
                end
            end
            ST_RD:   w_next = ST_CAP;
            ST_CAP:  w_next = r_op[3] ? ST_WR : ST_FIN;
            ST_WR:   w_next = ST_FIN;
            ST_FIN:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= ST_IDLE;
            r_op        <= '0;
            r_lane      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op       <= req_op;
                r_lane     <= req_addr[1:0];
                r_wdata    <= req_wdata;
                r_err      <= w_fault;
                r_mem_addr <= {2'b00, req_addr[31:2]};
                if (!w_fault && req_op == OP_SW) r_mem_wdata <= req_wdata;
            end
            // mem_rdata is valid here, one cycle after the MemRead strobe
            if (r_state == ST_CAP) begin
                if (r_op[3]) r_mem_wdata <= w_merged;
                else         r_rdata     <= w_load;
            end
        end
    end

    lsu_byte_lane u_lane (
        .i_size     (r_op[1:0]),
        .i_unsigned (r_op[2]),
        .i_lane     (r_lane),
        .i_word     (mem_rdata),
        .i_wdata    (r_wdata),
        .o_load     (w_load),
        .o_merged   (w_merged)
    );

    assign req_ready   = (r_state == ST_IDLE);
    assign done        = (r_state == ST_FIN);
    assign err         = (r_state == ST_FIN) && r_err;
    assign MemRead     = (r_state == ST_RD);
    assign MemWrite    = (r_state == ST_WR);
    assign mem_address = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign rdata       = r_rdata;

endmodule
